// File: rtl/serial_subtractor_pkg.sv
// Shared types and width limits for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_MIN_WIDTH = 2;
  localparam int SUB_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle between the operand source and the subtractor.
// The overflow signal exists only when SERIAL_SUB_SIGNED_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
  logic             overflow;
`endif

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit subtraction slice: diff = a - b - borrow_in.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first, one bit per clock.
// Define SERIAL_SUB_SIGNED_EN to add the signed overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < SUB_MIN_WIDTH || WIDTH > SUB_MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH out of supported range");
  end

  sub_state_t       state;
  sub_state_t       next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt;
  logic             borrow_r;
  logic             borrow_out_r;
  logic             bit_d;
  logic             bit_br;
  logic             last_bit;

  full_subtractor u_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (borrow_r),
    .diff       (bit_d),
    .borrow_out (bit_br)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (last_bit)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The result register fills from the top, so after WIDTH shifts bit 0 lands in diff[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr         <= '0;
      b_sr         <= '0;
      diff_r       <= '0;
      cnt          <= '0;
      borrow_r     <= 1'b0;
      borrow_out_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr         <= bus.a;
            b_sr         <= bus.b;
            borrow_r     <= bus.borrow_in;
            cnt          <= '0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          diff_r   <= {bit_d, diff_r[WIDTH-1:1]};
          borrow_r <= bit_br;
          if (last_bit) borrow_out_r <= bit_br;
          else          cnt          <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_EN
  logic overflow_r;

  // On the last bit the operand LSBs are the original sign bits and bit_d is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overflow_r <= 1'b0;
    else if (state == IDLE && bus.start) overflow_r <= 1'b0;
    else if (state == SHIFT && last_bit) overflow_r <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ bit_d);
  end

  assign bus.overflow = overflow_r;
`endif

  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
// Compile with SERIAL_SUB_SIGNED_EN defined to also check the overflow flag.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: plain integer subtraction, unsigned for borrow, signed range test for overflow.
  function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                                output logic [7:0] d, output logic bo, output logic ov);
    int ur;
    int sa;
    int sb;
    int sr;
    ur = int'(av) - int'(bv) - int'(bin);
    d  = ur[7:0];
    bo = (ur < 0);
    sa = $signed(av);
    sb = $signed(bv);
    sr = sa - sb - int'(bin);
    ov = (sr < -128) || (sr > 127);
  endfunction

  // Issues one request from IDLE and waits (bounded) for done; edges counts clock edges after acceptance.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                               output int edges, output logic got_done);
    @(negedge clk);
    bus.a         = av;
    bus.b         = bv;
    bus.borrow_in = bin;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    got_done = (bus.done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.diff !== 8'h00) begin errors++; $display("[TB] FAIL reset_diff got=%h want=00", bus.diff); end
    checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow got=%b want=0", bus.borrow_out); end
`ifdef SERIAL_SUB_SIGNED_EN
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b want=0", bus.overflow); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_reset busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_arith();
    logic [7:0] da [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h10};
    logic [7:0] db [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'h01};
    logic       dc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] av, bv, ed;
    logic       bin, eb, eo, got;
    int         edges;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin
        av = da[i]; bv = db[i]; bin = dc[i];
      end else begin
        av = 8'($urandom); bv = 8'($urandom); bin = 1'($urandom);
      end
      model(av, bv, bin, ed, eb, eo);
      applyStimulus(av, bv, bin, edges, got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL done_timeout op=%0d a=%h b=%h", i, av, bv); end
      checks++; if (edges != WIDTH) begin errors++; $display("[TB] FAIL latency op=%0d got=%0d want=%0d", i, edges, WIDTH); end
      checks++; if (bus.diff !== ed) begin
        errors++; $display("[TB] FAIL diff a=%h b=%h bin=%b got=%h want=%h", av, bv, bin, bus.diff, ed);
      end
      checks++; if (bus.borrow_out !== eb) begin
        errors++; $display("[TB] FAIL borrow_out a=%h b=%h bin=%b got=%b want=%b", av, bv, bin, bus.borrow_out, eb);
      end
`ifdef SERIAL_SUB_SIGNED_EN
      checks++; if (bus.overflow !== eo) begin
        errors++; $display("[TB] FAIL overflow a=%h b=%h bin=%b got=%b want=%b", av, bv, bin, bus.overflow, eo);
      end
`endif
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width got=%b want=0", bus.done); end
      checks++; if (bus.diff !== ed) begin errors++; $display("[TB] FAIL diff_hold got=%h want=%h", bus.diff, ed); end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int busy_seen = 0;
    int n = 0;
    @(negedge clk);
    bus.a = 8'h05; bus.b = 8'h03; bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_accept got=%b want=1", bus.busy); end
    repeat (3) @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h00; bus.borrow_in = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done_timeout got=%b want=1", bus.done); end
    if (bus.done === 1'b1) dones++;
    bus.a = 8'h40; bus.b = 8'h01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL ignore_done_count got=%0d want=1", dones); end
    checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL ignore_busy_cycles got=%0d want=0", busy_seen); end
    checks++; if (bus.diff !== 8'h02) begin errors++; $display("[TB] FAIL ignore_diff got=%h want=02", bus.diff); end
    checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL ignore_borrow got=%b want=0", bus.borrow_out); end
  endtask

  task automatic test_reset_abort();
    int   dones = 0;
    int   edges;
    logic got;
    @(negedge clk);
    bus.a = 8'h3C; bus.b = 8'h0F; bus.borrow_in = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got=%b want=0", bus.done); end
    checks++; if (bus.diff !== 8'h00) begin errors++; $display("[TB] FAIL abort_diff got=%h want=00", bus.diff); end
    checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL abort_borrow got=%b want=0", bus.borrow_out); end
`ifdef SERIAL_SUB_SIGNED_EN
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL abort_overflow got=%b want=0", bus.overflow); end
`endif
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("[TB] FAIL abort_spurious_done got=%0d want=0", dones); end
    applyStimulus(8'hAA, 8'h55, 1'b0, edges, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL post_abort_timeout got=%b want=1", got); end
    checks++; if (bus.diff !== 8'h55) begin errors++; $display("[TB] FAIL post_abort_diff got=%h want=55", bus.diff); end
    checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL post_abort_borrow got=%b want=0", bus.borrow_out); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int prev = -1;
    int pulses = 0;
    repeat (2) @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h01; bus.borrow_in = 1'b0; bus.start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        pulses++;
        checks++; if (bus.diff !== 8'hFE) begin errors++; $display("[TB] FAIL b2b_diff got=%h want=fe", bus.diff); end
        checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_borrow got=%b want=0", bus.borrow_out); end
        if (prev >= 0) begin
          checks++; if (cyc - prev != WIDTH + 2) begin
            errors++; $display("[TB] FAIL b2b_period got=%0d want=%0d", cyc - prev, WIDTH + 2);
          end
        end
        prev = cyc;
      end
    end
    bus.start = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("[TB] FAIL b2b_pulse_count got=%0d want=4", pulses); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] serial_subtractor bench starting");
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
